// File: rtl/dvi_timing_pkg.sv
// Shared definitions for the DVI timing sequencer and its encoder companions.
// Holds the phase encoding, the DVI control-period codewords and the colour-bar palette
// used when the DVI_TIMING_CTRL_TESTPAT_EN build option is defined.
package dvi_timing_pkg;

    // Phase of one timing axis (horizontal in clocks, vertical in lines).
    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_e;

    // TMDS control-period codewords indexed by {C1,C0}.
    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    // Colour-bar palette, packed {R,G,B}.
    localparam logic [23:0] BAR_WHITE   = 24'hFF_FF_FF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFF_FF_00;
    localparam logic [23:0] BAR_CYAN    = 24'h00_FF_FF;
    localparam logic [23:0] BAR_GREEN   = 24'h00_FF_00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF_00_FF;
    localparam logic [23:0] BAR_RED     = 24'hFF_00_00;
    localparam logic [23:0] BAR_BLUE    = 24'h00_00_FF;
    localparam logic [23:0] BAR_BLACK   = 24'h00_00_00;
    localparam int unsigned NUM_BARS    = 8;

    function automatic logic [9:0] ctrl_token(input logic [1:0] c1c0);
        logic [9:0] tok;
        unique case (c1c0)
            2'b00:   tok = CTRL_TOKEN_00;
            2'b01:   tok = CTRL_TOKEN_01;
            2'b10:   tok = CTRL_TOKEN_10;
            default: tok = CTRL_TOKEN_11;
        endcase
        return tok;
    endfunction

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [23:0] rgb;
        unique case (idx)
            3'd0:    rgb = BAR_WHITE;
            3'd1:    rgb = BAR_YELLOW;
            3'd2:    rgb = BAR_CYAN;
            3'd3:    rgb = BAR_GREEN;
            3'd4:    rgb = BAR_MAGENTA;
            3'd5:    rgb = BAR_RED;
            3'd6:    rgb = BAR_BLUE;
            default: rgb = BAR_BLACK;
        endcase
        return rgb;
    endfunction

    function automatic phase_e next_phase(input phase_e ph);
        phase_e nxt;
        unique case (ph)
            PH_ACT:  nxt = PH_FP;
            PH_FP:   nxt = PH_SYNC;
            PH_SYNC: nxt = PH_BP;
            default: nxt = PH_ACT;
        endcase
        return nxt;
    endfunction

    // Counter width able to hold the longest phase length.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/dvi_timing_axis.sv
// One timing axis: ACT -> FP -> SYNC -> BP phase FSM with a per-phase counter.
// Used once for the horizontal axis (advance every clock) and once for the vertical axis
// (advance on the last clock of each line). 'last' flags the final count of BP.
module dvi_timing_axis
    import dvi_timing_pkg::*;
#(
    parameter int unsigned LEN_ACT  = 640,
    parameter int unsigned LEN_FP   = 16,
    parameter int unsigned LEN_SYNC = 96,
    parameter int unsigned LEN_BP   = 48,
    parameter int unsigned CW       = cnt_width(LEN_ACT, LEN_FP, LEN_SYNC, LEN_BP)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold,
    input  logic          advance,
    output phase_e        phase,
    output logic [CW-1:0] count,
    output logic          last
);

    phase_e        phase_q, phase_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] len_m1;
    logic          end_of_phase;

    // Next-state: hold parks the axis at (ACT,0); otherwise step the phase counter.
    always_comb begin
        phase_d = phase_q;
        count_d = count_q;
        unique case (phase_q)
            PH_ACT:  len_m1 = CW'(LEN_ACT - 1);
            PH_FP:   len_m1 = CW'(LEN_FP - 1);
            PH_SYNC: len_m1 = CW'(LEN_SYNC - 1);
            default: len_m1 = CW'(LEN_BP - 1);
        endcase
        end_of_phase = (count_q == len_m1);
        last         = ~hold & advance & end_of_phase & (phase_q == PH_BP);
        if (hold) begin
            phase_d = PH_ACT;
            count_d = '0;
        end else if (advance) begin
            if (end_of_phase) begin
                phase_d = next_phase(phase_q);
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Phase and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PH_ACT;
            count_q <= '0;
        end else begin
            phase_q <= phase_d;
            count_q <= count_d;
        end
    end

    assign phase = phase_q;
    assign count = count_q;

endmodule

// File: rtl/dvi_timing_ctrl.sv
// Video timing sequencer feeding three dvi_encoder channels (ch0=B, ch1=G, ch2=R).
// The H/V axis state is the T0 stage; pixels are registered one cycle later (T1) and the
// DE/HSYNC/VSYNC controls trail by 1+DATA_LEAD cycles so D leads them into the encoders.
// Build option DVI_TIMING_CTRL_TESTPAT_EN adds input testpat_sel selecting internal colour bars.
module dvi_timing_ctrl
    import dvi_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter int unsigned DATA_LEAD = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    input  logic        underflow_clr,
`ifdef DVI_TIMING_CTRL_TESTPAT_EN
    input  logic        testpat_sel,
`endif
    output logic        pix_ready,
    output logic [7:0]  enc_d0,
    output logic [7:0]  enc_d1,
    output logic [7:0]  enc_d2,
    output logic        enc_c0,
    output logic        enc_c1,
    output logic        enc_de,
    output logic        frame_start,
    output logic        underflow
);

    localparam int unsigned HCW = cnt_width(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned VCW = cnt_width(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned DL  = DATA_LEAD + 1;

    phase_e           h_phase, v_phase;
    logic [HCW-1:0]   h_count;
    logic [VCW-1:0]   v_count;
    logic             h_last, v_last;
    logic             hold;

    logic             run, de_t0, tp_on;
    logic             de_in, hs_in, vs_in;
    logic [23:0]      pix_d, pix_q;
    logic             uf_d, uf_q;
    logic [DL-1:0]    de_sr_d, de_sr_q;
    logic [DL-1:0]    hs_sr_d, hs_sr_q;
    logic [DL-1:0]    vs_sr_d, vs_sr_q;
    logic             unused_v_last;

    assign hold          = ~enable;
    assign unused_v_last = v_last;

    dvi_timing_axis #(
        .LEN_ACT  (H_ACTIVE),
        .LEN_FP   (H_FP),
        .LEN_SYNC (H_SYNC),
        .LEN_BP   (H_BP),
        .CW       (HCW)
    ) u_h_axis (
        .clk     (clk),
        .reset   (reset),
        .hold    (hold),
        .advance (1'b1),
        .phase   (h_phase),
        .count   (h_count),
        .last    (h_last)
    );

    dvi_timing_axis #(
        .LEN_ACT  (V_ACTIVE),
        .LEN_FP   (V_FP),
        .LEN_SYNC (V_SYNC),
        .LEN_BP   (V_BP),
        .CW       (VCW)
    ) u_v_axis (
        .clk     (clk),
        .reset   (reset),
        .hold    (hold),
        .advance (h_last),
        .phase   (v_phase),
        .count   (v_count),
        .last    (v_last)
    );

`ifdef DVI_TIMING_CTRL_TESTPAT_EN
    localparam int unsigned BAR_W = (H_ACTIVE >= NUM_BARS) ? H_ACTIVE / NUM_BARS : 1;
    logic [2:0] bar_idx;

    // Bar index from the horizontal position; the last bar absorbs any remainder.
    always_comb begin
        bar_idx = 3'd7;
        if ((32'(h_count) / BAR_W) < 32'd7) bar_idx = 3'(32'(h_count) / BAR_W);
    end
    assign tp_on = testpat_sel;
`else
    assign tp_on = 1'b0;
`endif

    // T0 decode: timing values entering the control delay lines and the pixel handshake.
    always_comb begin
        // Reset is gated in so nothing is requested or flagged while it is held.
        run         = enable & ~reset;
        de_t0       = (h_phase == PH_ACT) && (v_phase == PH_ACT);
        de_in       = de_t0 & run;
        hs_in       = (run && h_phase == PH_SYNC) ? HS_POL : ~HS_POL;
        vs_in       = (run && v_phase == PH_SYNC) ? VS_POL : ~VS_POL;
        pix_ready   = de_t0 & run & ~tp_on;
        frame_start = de_in & (h_count == '0) & (v_count == '0);
    end

    // Pixel stage and sticky underflow; a starved pixel is sent as black.
    always_comb begin
        pix_d = '0;
        if (pix_ready && pix_valid) begin
            pix_d = pix_data;
        end
`ifdef DVI_TIMING_CTRL_TESTPAT_EN
        else if (tp_on && de_in) begin
            pix_d = bar_rgb(bar_idx);
        end
`endif
        uf_d = uf_q;
        if (pix_ready && !pix_valid) begin
            uf_d = 1'b1;
        end else if (underflow_clr) begin
            uf_d = 1'b0;
        end
    end

    // Control delay lines: stage 0 takes T0, output is the oldest stage.
    always_comb begin
        de_sr_d    = de_sr_q;
        hs_sr_d    = hs_sr_q;
        vs_sr_d    = vs_sr_q;
        de_sr_d[0] = de_in;
        hs_sr_d[0] = hs_in;
        vs_sr_d[0] = vs_in;
        for (int i = 1; i < DL; i++) begin
            de_sr_d[i] = de_sr_q[i-1];
            hs_sr_d[i] = hs_sr_q[i-1];
            vs_sr_d[i] = vs_sr_q[i-1];
        end
    end

    // Output registers; reset flushes the delay lines to the blank state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q   <= '0;
            uf_q    <= 1'b0;
            de_sr_q <= '0;
            hs_sr_q <= {DL{~HS_POL}};
            vs_sr_q <= {DL{~VS_POL}};
        end else begin
            pix_q   <= pix_d;
            uf_q    <= uf_d;
            de_sr_q <= de_sr_d;
            hs_sr_q <= hs_sr_d;
            vs_sr_q <= vs_sr_d;
        end
    end

    assign enc_d0    = pix_q[7:0];
    assign enc_d1    = pix_q[15:8];
    assign enc_d2    = pix_q[23:16];
    assign enc_de    = de_sr_q[DL-1];
    assign enc_c0    = hs_sr_q[DL-1];
    assign enc_c1    = vs_sr_q[DL-1];
    assign underflow = uf_q;

endmodule
